cpu_interrupt_sequencer: RTL and testbench

//  Generalised vector/interrupt sequencer for the 6502 core. Runs the 7-cycle RESET, NMI and IRQ

---
 rtl/cpu_interrupt_sequencer_if.sv | 27 ++
 rtl/cpu_interrupt_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_interrupt_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_interrupt_sequencer_if.sv
// rtl/cpu_interrupt_sequencer_if.sv - bus owned by the interrupt sequencer while it runs
interface cpu_interrupt_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              o_rw;
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] o_data;
    logic              o_busy;
    logic [DATA_W-1:0] i_data;

    modport master (
        output o_rw,
        output o_address,
        output o_data,
        output o_busy,
        input  i_data
    );

    modport slave (
        input  o_rw,
        input  o_address,
        input  o_data,
        input  o_busy,
        output i_data
    );
endinterface

// File: rtl/cpu_interrupt_sequencer.sv
// rtl/cpu_interrupt_sequencer.sv - 7-cycle RESET/NMI/IRQ sequencer for the 6502 core
module cpu_interrupt_sequencer #(
    parameter int                       ADDR_W       = 16,
    parameter int                       DATA_W       = 8,
    parameter logic [ADDR_W-1:0]        VECTOR_NMI   = 'hFFFA,
    parameter logic [ADDR_W-1:0]        VECTOR_RESET = 'hFFFC,
    parameter logic [ADDR_W-1:0]        VECTOR_IRQ   = 'hFFFE,
    parameter logic [ADDR_W-DATA_W-1:0] STACK_PAGE   = 'h01
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_nmi_n,
    input  logic                  i_irq_n,
    input  logic                  i_i_flag,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_pc,
    input  logic [DATA_W-1:0]     i_status,
    input  logic [DATA_W-1:0]     i_sp,
    cpu_interrupt_sequencer_if.master bus,
    output logic [ADDR_W-1:0]     o_pc,
    output logic                  o_pc_valid,
    output logic [DATA_W-1:0]     o_sp,
    output logic                  o_set_i,
    output logic [7:0]            o_debug_state
);

    // RST0 doubles as the first dummy read of the reset sequence, so it
    // must encode as zero for the debug port to read 0 during reset.
    typedef enum logic [3:0] {
        ST_RST0 = 4'd0,
        ST_IDLE = 4'd1,
        ST_D0   = 4'd2,
        ST_D1   = 4'd3,
        ST_S0   = 4'd4,
        ST_S1   = 4'd5,
        ST_S2   = 4'd6,
        ST_VL   = 4'd7,
        ST_VH   = 4'd8,
        ST_DONE = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        SEQ_RESET = 2'd0,
        SEQ_NMI   = 2'd1,
        SEQ_IRQ   = 2'd2
    } seq_t;

    state_t            state_q;
    seq_t              seq_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] status_q;
    logic [DATA_W-1:0] sp_q;
    logic [ADDR_W-1:0] vec_q;
    logic [DATA_W-1:0] lo_q;

    logic              nmi_sync1_q;
    logic              nmi_sync2_q;
    logic              nmi_latch_q;

    logic              nmi_fall;
    logic              nmi_pending;
    logic              take_nmi_vec;
    logic              nmi_clr;
    logic              irq_req;
    logic [DATA_W-1:0] sp_dec;
    logic [ADDR_W-1:0] stack_addr_cur;
    logic [ADDR_W-1:0] stack_addr_dec;
    logic [DATA_W-1:0] push_status;
    logic [ADDR_W-1:0] vec_sel;

    // NMI edge is taken off the synchroniser pair; an edge arriving on the
    // very cycle it is consumed counts as pending so it is not lost or doubled.
    always_comb begin
        nmi_fall     = nmi_sync2_q & ~nmi_sync1_q;
        nmi_pending  = nmi_latch_q | nmi_fall;
        irq_req      = ~i_irq_n & ~i_i_flag;
        take_nmi_vec = (seq_q == SEQ_NMI) | ((seq_q == SEQ_IRQ) & nmi_pending);
        nmi_clr      = (state_q == ST_S2) & take_nmi_vec;
    end

    // Stack addressing, pushed status image and vector choice for the VL entry.
    always_comb begin
        sp_dec         = sp_q - DATA_W'(1);
        stack_addr_cur = {STACK_PAGE, sp_q};
        stack_addr_dec = {STACK_PAGE, sp_dec};
        push_status    = status_q;
        push_status[4] = 1'b0;
        push_status[5] = 1'b1;
        if (seq_q == SEQ_RESET) begin
            vec_sel = VECTOR_RESET;
        end else if (take_nmi_vec) begin
            vec_sel = VECTOR_NMI;
        end else begin
            vec_sel = VECTOR_IRQ;
        end
    end

    // NMI synchroniser and latch; consuming the latch wins over a new edge.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            nmi_sync1_q <= 1'b1;
            nmi_sync2_q <= 1'b1;
            nmi_latch_q <= 1'b0;
        end else begin
            nmi_sync1_q <= i_nmi_n;
            nmi_sync2_q <= nmi_sync1_q;
            if (nmi_clr) begin
                nmi_latch_q <= 1'b0;
            end else if (nmi_fall) begin
                nmi_latch_q <= 1'b1;
            end
        end
    end

    // Sequencer FSM; bus outputs are loaded with the values of the state being entered.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= ST_RST0;
            seq_q         <= SEQ_RESET;
            pc_q          <= '0;
            status_q      <= '0;
            sp_q          <= '0;
            vec_q         <= '0;
            lo_q          <= '0;
            bus.o_busy    <= 1'b1;
            bus.o_rw      <= 1'b1;
            bus.o_address <= '0;
            bus.o_data    <= '0;
            o_pc          <= '0;
            o_pc_valid    <= 1'b0;
            o_set_i       <= 1'b0;
            o_sp          <= '0;
        end else begin
            o_pc_valid <= 1'b0;
            o_set_i    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start && (nmi_pending || irq_req)) begin
                        seq_q         <= nmi_pending ? SEQ_NMI : SEQ_IRQ;
                        pc_q          <= i_pc;
                        status_q      <= i_status;
                        sp_q          <= i_sp;
                        state_q       <= ST_D0;
                        bus.o_busy    <= 1'b1;
                        bus.o_rw      <= 1'b1;
                        bus.o_address <= i_pc;
                        bus.o_data    <= '0;
                    end
                end
                ST_RST0, ST_D0: begin
                    state_q       <= ST_D1;
                    bus.o_rw      <= 1'b1;
                    bus.o_address <= pc_q;
                end
                ST_D1: begin
                    state_q       <= ST_S0;
                    bus.o_address <= stack_addr_cur;
                    if (seq_q == SEQ_RESET) begin
                        bus.o_rw   <= 1'b1;
                        bus.o_data <= '0;
                    end else begin
                        bus.o_rw   <= 1'b0;
                        bus.o_data <= DATA_W'(pc_q >> 8);
                    end
                end
                ST_S0: begin
                    state_q       <= ST_S1;
                    sp_q          <= sp_dec;
                    bus.o_address <= stack_addr_dec;
                    bus.o_data    <= (seq_q == SEQ_RESET) ? '0 : DATA_W'(pc_q[7:0]);
                end
                ST_S1: begin
                    state_q       <= ST_S2;
                    sp_q          <= sp_dec;
                    bus.o_address <= stack_addr_dec;
                    bus.o_data    <= (seq_q == SEQ_RESET) ? '0 : push_status;
                end
                ST_S2: begin
                    state_q       <= ST_VL;
                    sp_q          <= sp_dec;
                    vec_q         <= vec_sel;
                    bus.o_rw      <= 1'b1;
                    bus.o_address <= vec_sel;
                    bus.o_data    <= '0;
                end
                ST_VL: begin
                    state_q       <= ST_VH;
                    lo_q          <= bus.i_data;
                    bus.o_address <= vec_q + ADDR_W'(1);
                end
                ST_VH: begin
                    state_q    <= ST_DONE;
                    o_pc       <= ADDR_W'({bus.i_data, lo_q});
                    o_sp       <= sp_q;
                    o_pc_valid <= 1'b1;
                    o_set_i    <= 1'b1;
                end
                ST_DONE: begin
                    state_q       <= ST_IDLE;
                    bus.o_busy    <= 1'b0;
                    bus.o_rw      <= 1'b1;
                    bus.o_address <= '0;
                    bus.o_data    <= '0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    bus.o_busy <= 1'b0;
                    bus.o_rw   <= 1'b1;
                end
            endcase
        end
    end

    assign o_debug_state = {4'd0, state_q};

endmodule

// File: tb/tb_cpu_interrupt_sequencer.sv
// tb/tb_cpu_interrupt_sequencer.sv - directed vector bench for cpu_interrupt_sequencer
module tb_cpu_interrupt_sequencer;

    logic        clk = 1'b1;
    logic        i_reset_n;
    logic        i_nmi_n;
    logic        i_irq_n;
    logic        i_i_flag;
    logic        i_start;
    logic [15:0] i_pc;
    logic [7:0]  i_status;
    logic [7:0]  i_sp;
    logic [15:0] o_pc;
    logic        o_pc_valid;
    logic [7:0]  o_sp;
    logic        o_set_i;
    logic [7:0]  o_debug_state;

    cpu_interrupt_sequencer_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    cpu_interrupt_sequencer dut (
        .i_clk         (clk),
        .i_reset_n     (i_reset_n),
        .i_nmi_n       (i_nmi_n),
        .i_irq_n       (i_irq_n),
        .i_i_flag      (i_i_flag),
        .i_start       (i_start),
        .i_pc          (i_pc),
        .i_status      (i_status),
        .i_sp          (i_sp),
        .bus           (bus),
        .o_pc          (o_pc),
        .o_pc_valid    (o_pc_valid),
        .o_sp          (o_sp),
        .o_set_i       (o_set_i),
        .o_debug_state (o_debug_state)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (bus.o_address)
            16'hFFFA: bus.i_data = 8'h00;
            16'hFFFB: bus.i_data = 8'hA0;
            16'hFFFC: bus.i_data = 8'h00;
            16'hFFFD: bus.i_data = 8'h80;
            16'hFFFE: bus.i_data = 8'h00;
            16'hFFFF: bus.i_data = 8'h90;
            default:  bus.i_data = 8'hEE;
        endcase
    end

    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    logic [15:0] vl_addr;
    bit          saw_busy;

    typedef struct {
        logic        irq_n;
        logic        iflag;
        logic        start;
        logic [7:0]  st;
        logic        busy;
        logic        rw;
        logic        ca;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        valid;
        logic [15:0] pc;
        logic [7:0]  sp;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
        if (bus.o_busy && !bus.o_rw) begin
            wr_a.push_back(bus.o_address);
            wr_d.push_back(bus.o_data);
        end
        if (o_debug_state == 8'd7) vl_addr = bus.o_address;
        if (bus.o_busy) saw_busy = 1'b1;
    endtask

    task automatic run_until_done(input string nm, input int max);
        int n  = 0;
        bit ok = 1'b0;
        while (!ok && n < max) begin
            tick();
            n++;
            if (o_pc_valid) ok = 1'b1;
        end
        chk({nm, "_done"}, 32'(ok), 32'd1);
        chk({nm, "_set_i"}, 32'(o_set_i), 32'd1);
    endtask

    task automatic chk_push(input string nm, input int idx, input logic [15:0] a, input logic [7:0] d);
        if (idx < wr_a.size()) begin
            chk($sformatf("%s_push%0d_addr", nm, idx), 32'(wr_a[idx]), 32'(a));
            chk($sformatf("%s_push%0d_data", nm, idx), 32'(wr_d[idx]), 32'(d));
        end else begin
            chk($sformatf("%s_push%0d_missing", nm, idx), 32'(wr_a.size()), 32'(idx + 1));
        end
    endtask

    task automatic clear_log();
        wr_a.delete();
        wr_d.delete();
        vl_addr = 16'h0;
    endtask

    initial begin
        int nwr;

        // irq_n iflag start | state busy rw ca addr data valid pc sp
        tbl[0]  = '{1, 1, 0, 8'd3, 1, 1, 1, 16'h0000, 8'h00, 0, 16'h0000, 8'h00};
        tbl[1]  = '{1, 1, 0, 8'd4, 1, 1, 1, 16'h0100, 8'h00, 0, 16'h0000, 8'h00};
        tbl[2]  = '{1, 1, 0, 8'd5, 1, 1, 1, 16'h01FF, 8'h00, 0, 16'h0000, 8'h00};
        tbl[3]  = '{1, 1, 0, 8'd6, 1, 1, 1, 16'h01FE, 8'h00, 0, 16'h0000, 8'h00};
        tbl[4]  = '{1, 1, 0, 8'd7, 1, 1, 1, 16'hFFFC, 8'h00, 0, 16'h0000, 8'h00};
        tbl[5]  = '{1, 1, 0, 8'd8, 1, 1, 1, 16'hFFFD, 8'h00, 0, 16'h0000, 8'h00};
        tbl[6]  = '{1, 1, 0, 8'd9, 1, 1, 0, 16'h0000, 8'h00, 1, 16'h8000, 8'hFD};
        tbl[7]  = '{1, 1, 0, 8'd1, 0, 1, 0, 16'h0000, 8'h00, 0, 16'h8000, 8'hFD};
        tbl[8]  = '{0, 1, 1, 8'd1, 0, 1, 0, 16'h0000, 8'h00, 0, 16'h8000, 8'hFD};
        tbl[9]  = '{0, 1, 1, 8'd1, 0, 1, 0, 16'h0000, 8'h00, 0, 16'h8000, 8'hFD};
        tbl[10] = '{0, 0, 1, 8'd2, 1, 1, 1, 16'h1234, 8'h00, 0, 16'h8000, 8'hFD};
        tbl[11] = '{0, 0, 0, 8'd3, 1, 1, 1, 16'h1234, 8'h00, 0, 16'h8000, 8'hFD};
        tbl[12] = '{0, 0, 0, 8'd4, 1, 0, 1, 16'h01FF, 8'h12, 0, 16'h8000, 8'hFD};
        tbl[13] = '{0, 0, 0, 8'd5, 1, 0, 1, 16'h01FE, 8'h34, 0, 16'h8000, 8'hFD};
        tbl[14] = '{0, 0, 0, 8'd6, 1, 0, 1, 16'h01FD, 8'hA5, 0, 16'h8000, 8'hFD};
        tbl[15] = '{0, 0, 0, 8'd7, 1, 1, 1, 16'hFFFE, 8'h00, 0, 16'h8000, 8'hFD};
        tbl[16] = '{0, 0, 0, 8'd8, 1, 1, 1, 16'hFFFF, 8'h00, 0, 16'h8000, 8'hFD};
        tbl[17] = '{0, 0, 0, 8'd9, 1, 1, 0, 16'h0000, 8'h00, 1, 16'h9000, 8'hFC};
        tbl[18] = '{1, 0, 0, 8'd1, 0, 1, 0, 16'h0000, 8'h00, 0, 16'h9000, 8'hFC};

        i_reset_n = 1'b0;
        i_nmi_n   = 1'b1;
        i_irq_n   = 1'b1;
        i_i_flag  = 1'b1;
        i_start   = 1'b0;
        i_pc      = 16'h1234;
        i_status  = 8'hA5;
        i_sp      = 8'hFF;
        vl_addr   = 16'h0;
        saw_busy  = 1'b0;

        tick();
        tick();
        chk("rst_busy",  32'(bus.o_busy), 32'd1);
        chk("rst_rw",    32'(bus.o_rw), 32'd1);
        chk("rst_addr",  32'(bus.o_address), 32'h0);
        chk("rst_data",  32'(bus.o_data), 32'h0);
        chk("rst_pc",    32'(o_pc), 32'h0);
        chk("rst_valid", 32'(o_pc_valid), 32'd0);
        chk("rst_set_i", 32'(o_set_i), 32'd0);
        chk("rst_sp",    32'(o_sp), 32'h0);
        chk("rst_state", 32'(o_debug_state), 32'h0);
        i_reset_n = 1'b1;

        // Reset sequence, IRQ masked by I flag, then the IRQ sequence.
        for (int i = 0; i < 19; i++) begin
            i_irq_n  = tbl[i].irq_n;
            i_i_flag = tbl[i].iflag;
            i_start  = tbl[i].start;
            tick();
            chk($sformatf("row%0d_state", i), 32'(o_debug_state), 32'(tbl[i].st));
            chk($sformatf("row%0d_busy", i),  32'(bus.o_busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d_rw", i),    32'(bus.o_rw), 32'(tbl[i].rw));
            if (tbl[i].ca)
                chk($sformatf("row%0d_addr", i), 32'(bus.o_address), 32'(tbl[i].addr));
            if (!tbl[i].rw)
                chk($sformatf("row%0d_data", i), 32'(bus.o_data), 32'(tbl[i].data));
            chk($sformatf("row%0d_valid", i), 32'(o_pc_valid), 32'(tbl[i].valid));
            chk($sformatf("row%0d_set_i", i), 32'(o_set_i), 32'(tbl[i].valid));
            chk($sformatf("row%0d_pc", i),    32'(o_pc), 32'(tbl[i].pc));
            chk($sformatf("row%0d_sp", i),    32'(o_sp), 32'(tbl[i].sp));
        end

        // NMI and IRQ pending together: NMI wins; stack wraps 00 -> FF.
        i_nmi_n  = 1'b0;
        i_pc     = 16'hABCD;
        i_status = 8'h10;
        i_sp     = 8'h02;
        saw_busy = 1'b0;
        repeat (3) tick();
        chk("t4_idle_before", 32'(saw_busy), 32'd0);
        clear_log();
        i_irq_n  = 1'b0;
        i_i_flag = 1'b0;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        i_irq_n = 1'b1;
        run_until_done("t4", 20);
        chk("t4_vector", 32'(vl_addr), 32'hFFFA);
        chk("t4_pc", 32'(o_pc), 32'hA000);
        chk("t4_sp", 32'(o_sp), 32'hFF);
        chk("t4_npush", 32'(wr_a.size()), 32'd3);
        chk_push("t4", 0, 16'h0102, 8'hAB);
        chk_push("t4", 1, 16'h0101, 8'hCD);
        chk_push("t4", 2, 16'h0100, 8'h20);
        i_start  = 1'b1;
        saw_busy = 1'b0;
        repeat (6) tick();
        chk("t4_no_retrigger", 32'(saw_busy), 32'd0);
        i_start = 1'b0;

        // NMI edge during IRQ S1 hijacks the vector.
        i_nmi_n = 1'b1;
        repeat (3) tick();
        i_pc     = 16'h0042;
        i_status = 8'hFF;
        i_sp     = 8'h80;
        clear_log();
        i_irq_n  = 1'b0;
        i_i_flag = 1'b0;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (3) tick();
        chk("t5_in_s1", 32'(o_debug_state), 32'd5);
        i_nmi_n = 1'b0;
        run_until_done("t5", 20);
        chk("t5_vector", 32'(vl_addr), 32'hFFFA);
        chk("t5_pc", 32'(o_pc), 32'hA000);
        chk("t5_sp", 32'(o_sp), 32'h7D);
        chk("t5_npush", 32'(wr_a.size()), 32'd3);
        chk_push("t5", 0, 16'h0180, 8'h00);
        chk_push("t5", 1, 16'h017F, 8'h42);
        chk_push("t5", 2, 16'h017E, 8'hEF);
        i_irq_n  = 1'b1;
        i_start  = 1'b1;
        tick();
        saw_busy = 1'b0;
        repeat (6) tick();
        chk("t5_latch_clear", 32'(saw_busy), 32'd0);
        chk("t5_idle", 32'(o_debug_state), 32'd1);
        i_start = 1'b0;

        // Reset asserted during IRQ S1 aborts the sequence.
        i_nmi_n  = 1'b1;
        i_pc     = 16'h5555;
        i_status = 8'h00;
        i_sp     = 8'h40;
        repeat (3) tick();
        clear_log();
        i_irq_n  = 1'b0;
        i_i_flag = 1'b0;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (3) tick();
        chk("t6_in_s1", 32'(o_debug_state), 32'd5);
        #1;
        i_reset_n = 1'b0;
        nwr = wr_a.size();
        #1;
        chk("t6_busy",  32'(bus.o_busy), 32'd1);
        chk("t6_rw",    32'(bus.o_rw), 32'd1);
        chk("t6_addr",  32'(bus.o_address), 32'h0);
        chk("t6_valid", 32'(o_pc_valid), 32'd0);
        chk("t6_pc",    32'(o_pc), 32'h0);
        chk("t6_sp",    32'(o_sp), 32'h0);
        chk("t6_state", 32'(o_debug_state), 32'h0);
        repeat (2) tick();
        i_irq_n   = 1'b1;
        i_reset_n = 1'b1;
        run_until_done("t6", 20);
        chk("t6_no_more_writes", 32'(wr_a.size()), 32'(nwr));
        chk("t6_pre_writes", 32'(nwr), 32'd2);
        for (int k = 0; k < wr_a.size(); k++)
            if (wr_a[k] == 16'h013E) chk("t6_s2_write", 32'(wr_a[k]), 32'h0);
        chk("t6_pc_after", 32'(o_pc), 32'h8000);
        chk("t6_sp_after", 32'(o_sp), 32'hFD);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
